// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the LC-3b pipelined datapath: pipe-reg load enables, valid bits, PC load, stalls.
// Latency: enables/stalls are combinational from inputs and registered state; valid bits update on the next edge.
// Backpressure: D-mem wait holds PC and regs 0..MEM_IDX; a RAW hazard holds PC and reg 0; redirect flushes 0..BR_IDX.
module pipe_hazard_ctrl #(
   parameter int NUM_STAGES = 5,
   parameter int NUM_REGS   = 8,
   parameter int REG_W      = $clog2(NUM_REGS),
   parameter int MEM_IDX    = 2,
   parameter int BR_IDX     = 2,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  if_resp,
   input  logic [REG_W-1:0]      dec_src_a,
   input  logic                  dec_use_a,
   input  logic [REG_W-1:0]      dec_src_b,
   input  logic                  dec_use_b,
   input  logic [REG_W-1:0]      dec_dest,
   input  logic                  dec_wr,
   input  logic                  dec_set_cc,
   input  logic                  dec_use_cc,
   input  logic                  mem_req,
   input  logic                  mem_resp,
   input  logic                  redirect,
   output logic                  load_pc,
   output logic [NUM_STAGES-2:0] load_stage,
   output logic [NUM_STAGES-2:0] valid,
   output logic                  hazard,
   output logic                  mem_stall,
   output logic                  retire,
   output logic [CNT_W-1:0]      stall_count
);

   // Number of pipe registers; reg 0 is IF/ID, reg NP-1 feeds writeback.
   localparam int NP = NUM_STAGES - 1;

   // Valid bit per pipe reg, plus a shadow of {dest,wr,set_cc} for regs 1..NP-1.
   logic [NP-1:0]    r_valid;
   logic [REG_W-1:0] r_dest [NP-1:1];
   logic [NP-1:1]    r_wr;
   logic [NP-1:1]    r_cc;
   logic [CNT_W-1:0] r_stall_cnt;

   logic [NUM_REGS-1:0] w_pend;
   logic                w_cc_pend;
   logic                w_mem_stall;
   logic                w_raw;
   logic                w_hazard;
   logic                w_redirect;
   logic                w_load_pc;
   logic [NP-1:0]       w_load;
   logic [NP-1:0]       w_vnext;
   logic [REG_W-1:0]    w_dest_in [NP-1:1];
   logic [NP-1:1]       w_wr_in;
   logic [NP-1:1]       w_cc_in;

   // Pending-writer scoreboard: every occupied reg past decode, including writeback, blocks its dest and CC.
   always_comb begin
      w_pend    = '0;
      w_cc_pend = 1'b0;
      for (int k = 1; k < NP; k++) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (r_valid[k] && r_wr[k] && (r_dest[k] == REG_W'(r))) begin
               w_pend[r] = 1'b1;
            end
         end
         if (r_valid[k] && r_cc[k]) begin
            w_cc_pend = 1'b1;
         end
      end
   end

   // Stall and redirect qualification; D-mem wait outranks everything, a deferred redirect waits for it.
   always_comb begin
      w_mem_stall = r_valid[MEM_IDX] & mem_req & ~mem_resp;
      w_raw       = r_valid[0] & ((dec_use_a  & w_pend[dec_src_a]) |
                                  (dec_use_b  & w_pend[dec_src_b]) |
                                  (dec_use_cc & w_cc_pend));
      w_hazard    = w_raw & ~w_mem_stall;
      w_redirect  = redirect & r_valid[BR_IDX] & ~w_mem_stall;
   end

   // Per-reg hold/bubble selection: mem_stall > redirect > hazard > normal fetch.
   always_comb begin
      w_load    = '1;
      w_vnext   = {r_valid[NP-2:0], if_resp};
      w_load_pc = if_resp;
      if (w_mem_stall) begin
         w_load_pc = 1'b0;
         for (int k = 0; k < NP; k++) begin
            if (k <= MEM_IDX) begin
               w_load[k]  = 1'b0;
               w_vnext[k] = r_valid[k];
            end else if (k == MEM_IDX + 1) begin
               w_vnext[k] = 1'b0;
            end
         end
      end else if (w_redirect) begin
         // Everything younger than the redirecting instr is squashed; it moves on to BR_IDX+1.
         w_load_pc = 1'b1;
         for (int k = 0; k < NP; k++) begin
            if (k <= BR_IDX) begin
               w_vnext[k] = 1'b0;
            end
         end
      end else if (w_hazard) begin
         w_load_pc  = 1'b0;
         w_load[0]  = 1'b0;
         w_vnext[0] = r_valid[0];
         w_vnext[1] = 1'b0;
      end
   end

   // Shadow data source for each reg: decode fields into reg 1, previous reg otherwise.
   always_comb begin
      w_dest_in[1] = dec_dest;
      w_wr_in[1]   = dec_wr;
      w_cc_in[1]   = dec_set_cc;
      for (int k = 2; k < NP; k++) begin
         w_dest_in[k] = r_dest[k-1];
         w_wr_in[k]   = r_wr[k-1];
         w_cc_in[k]   = r_cc[k-1];
      end
   end

   // Valid bits and shadow pipe; bubbles still load data but carry valid=0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= '0;
         r_wr    <= '0;
         r_cc    <= '0;
         for (int k = 1; k < NP; k++) begin
            r_dest[k] <= '0;
         end
      end else begin
         r_valid <= w_vnext;
         for (int k = 1; k < NP; k++) begin
            if (w_load[k]) begin
               r_dest[k] <= w_dest_in[k];
               r_wr[k]   <= w_wr_in[k];
               r_cc[k]   <= w_cc_in[k];
            end
         end
      end
   end

   // Saturating count of cycles spent in either kind of stall.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stall_cnt <= '0;
      end else if ((w_hazard || w_mem_stall) && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   // Combinational outputs are held low while reset is asserted.
   always_comb begin
      load_pc     = reset_n & w_load_pc;
      load_stage  = w_load & {NP{reset_n}};
      hazard      = reset_n & w_hazard;
      mem_stall   = reset_n & w_mem_stall;
      valid       = r_valid;
      retire      = r_valid[NP-1];
      stall_count = r_stall_cnt;
   end

endmodule
